imgproc_bbox_poller: RTL
========================

// Module: imgproc_bbox_poller
// PURPOSE
//  Avalon-MM master that sequences the image-processing block's MM slave: on reset it flushes the
//  message FIFO and programs the box colour, then polls the status register and drains 3-word
//  "RBB" messages (ID, top-left, bottom-right). Each complete message is presented as one
//  valid/ready bounding-box record to the rover control logic. Sits between the vision
//  pipeline's slave port and the navigation/UART consumer.
// PARAMETERS
//  POLL_INTERVAL  1000          clk cycles between status polls while idle (>=2)
//  BB_COL_INIT    24'h00ff00    box colour written to REG_BBCOL after reset / cfg_update
//  MSG_ID         32'h00524242  expected ID word ("RBB")
// PORTS
//  clk            in   1   system clock
//  reset          in   1   asynchronous, active-high reset
//  m_chipselect   out  1   to slave s_chipselect
//  m_read         out  1   to slave s_read; only ever a single-cycle pulse
//  m_write        out  1   to slave s_write; single-cycle pulse
//  m_address      out  3   0=STATUS 1=READ_MSG 2=READ_ID 3=BBCOL
//  m_writedata    out  32  write data
//  m_readdata     in   32  slave readdata, valid the cycle after m_read
//  cfg_update     in   1   pulse: rewrite bb_col_cfg to BBCOL at next IDLE
//  bb_col_cfg     in   24  colour used by cfg_update
//  bb_valid       out  1   record available
//  bb_ready       in   1   consumer accepts record when bb_valid&bb_ready
//  bb_x_min/bb_y_min/bb_x_max/bb_y_max  out 11 each  box corners
//  bb_none        out  1   1 when x_min>x_max or y_min>y_max (no detection that frame)
//  err_count      out  8   saturating count of ID mismatches
// BEHAVIOUR
//  - Reset: all outputs 0 (m_address 0, bb_* 0, err_count 0); state INIT_FLUSH.
//  - Bus rule: m_chipselect=1 exactly when m_read or m_write=1. Every read is followed by one
//    capture cycle with m_read=0 (slave pops FIFO on read rising edge; back-to-back reads forbidden).
//  - States (one cycle each unless stated):
//    INIT_FLUSH: write STATUS, data 32'h10 -> INIT_COL.
//    INIT_COL: write BBCOL, data {8'h0,colour} (BB_COL_INIT after reset, bb_col_cfg on update) -> IDLE.
//    IDLE: timer counts POLL_INTERVAL-1..0; at 0 -> RD_STAT; if cfg_update latched -> INIT_COL first.
//    RD_STAT (read addr 0) -> CAP_STAT: words=readdata[15:8]; words>=3 -> RD_ID, else IDLE (timer reloads).
//    RD_ID (addr 1) -> CAP_ID: readdata==MSG_ID -> RD_TL; else err_count++ (sat 255) -> INIT_FLUSH (resync).
//    RD_TL -> CAP_TL: x_min=rd[26:16], y_min=rd[10:0] -> RD_BR -> CAP_BR: x_max,y_max likewise -> OUT.
//    OUT: bb_valid=1, fields stable; on bb_ready -> RD_STAT if words-3>=3 (skip timer), else IDLE.
//  - Output fields update only on OUT entry; bb_valid deasserts the cycle after handshake.
//  - Latency: RD_STAT to bb_valid = 8 cycles. cfg_update during a message sequence is held
//    (sticky flag) and serviced at next IDLE; a second pulse while pending is merged.
//  - bb_none = (x_min>x_max)|(y_min>y_max), registered with the fields.
//  - Reset mid-sequence aborts immediately; partial message discarded, re-flush on exit.
// TESTING
//  1 Reset release -> write addr0 data 0x10, next cycle write addr3 data 0x00ff00, then idle.
//  2 Status words=3, msg "RBB",{x=100,y=50},{x=200,y=120} -> bb_valid, x_min=100 y_min=50
//    x_max=200 y_max=120 bb_none=0, 8 cycles after status read.
//  3 Status words=6, bb_ready held low 20 cycles -> fields stable; after accept second record
//    read with no POLL_INTERVAL gap; never two consecutive cycles with m_read=1.
//  4 ID word 0xDEADBEEF -> err_count=1, flush write to addr0 data 0x10, no bb_valid.
//  5 Message {639,479},{0,0} (empty frame) -> bb_none=1.
//  6 cfg_update with bb_col_cfg=0xff0000 during RD_TL -> message completes, then write addr3 0xff0000.

Source files
------------

// File: rtl/imgproc_bbox_poller_if.sv
// Bus bundle between the bounding-box poller, the vision block's Avalon-MM
// slave and the downstream record consumer.
interface imgproc_bbox_poller_if;
    // Avalon-MM side
    logic        m_chipselect;
    logic        m_read;
    logic        m_write;
    logic [2:0]  m_address;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    // bounding-box record side (valid/ready)
    logic        bb_valid;
    logic        bb_ready;
    logic [10:0] bb_x_min;
    logic [10:0] bb_y_min;
    logic [10:0] bb_x_max;
    logic [10:0] bb_y_max;
    logic        bb_none;

    modport master (
        output m_chipselect, m_read, m_write, m_address, m_writedata,
        input  m_readdata,
        output bb_valid, bb_x_min, bb_y_min, bb_x_max, bb_y_max, bb_none,
        input  bb_ready
    );

    modport slave (
        input  m_chipselect, m_read, m_write, m_address, m_writedata,
        output m_readdata,
        input  bb_valid, bb_x_min, bb_y_min, bb_x_max, bb_y_max, bb_none,
        output bb_ready
    );
endinterface

// File: rtl/imgproc_bbox_poller.sv
// Avalon-MM master that flushes and configures the vision block, polls its
// status register and drains 3-word "RBB" messages (ID, top-left,
// bottom-right) into one valid/ready bounding-box record each.
module imgproc_bbox_poller #(
    parameter int          POLL_INTERVAL = 1000,
    parameter logic [23:0] BB_COL_INIT   = 24'h00ff00,
    parameter logic [31:0] MSG_ID        = 32'h00524242
) (
    input  logic                  clk,
    input  logic                  reset,
    imgproc_bbox_poller_if.master bus,
    input  logic                  cfg_update,
    input  logic [23:0]           bb_col_cfg,
    output logic [7:0]            err_count
);

    localparam logic [3:0] S_INIT_FLUSH = 4'd0;
    localparam logic [3:0] S_INIT_COL   = 4'd1;
    localparam logic [3:0] S_IDLE       = 4'd2;
    localparam logic [3:0] S_RD_STAT    = 4'd3;
    localparam logic [3:0] S_CAP_STAT   = 4'd4;
    localparam logic [3:0] S_RD_ID      = 4'd5;
    localparam logic [3:0] S_CAP_ID     = 4'd6;
    localparam logic [3:0] S_RD_TL      = 4'd7;
    localparam logic [3:0] S_CAP_TL     = 4'd8;
    localparam logic [3:0] S_RD_BR      = 4'd9;
    localparam logic [3:0] S_CAP_BR     = 4'd10;
    localparam logic [3:0] S_OUT        = 4'd11;

    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_MSG    = 3'd1;
    localparam logic [2:0] ADDR_BBCOL  = 3'd3;

    localparam int            TW         = $clog2(POLL_INTERVAL);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(POLL_INTERVAL - 1);

    logic [3:0]    r_state;
    logic [3:0]    w_next;
    // Set one cycle after reset release so the flush write never appears while reset is held.
    logic          r_armed;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_words;
    logic [7:0]    r_err;
    logic          r_cfg_pend;
    logic [23:0]   r_col;
    logic [10:0]   r_tl_x;
    logic [10:0]   r_tl_y;
    logic [10:0]   r_x_min;
    logic [10:0]   r_y_min;
    logic [10:0]   r_x_max;
    logic [10:0]   r_y_max;
    logic          r_none;
    logic          r_valid;

    logic [7:0]    w_words;
    logic          w_id_ok;
    logic [10:0]   w_rd_x;
    logic [10:0]   w_rd_y;

    assign w_words = bus.m_readdata[15:8];
    assign w_id_ok = (bus.m_readdata == MSG_ID);
    assign w_rd_x  = bus.m_readdata[26:16];
    assign w_rd_y  = bus.m_readdata[10:0];

    // Next-state selection; every read state is followed by its capture state.
    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            S_INIT_FLUSH: if (r_armed) w_next = S_INIT_COL;
            S_INIT_COL:   w_next = S_IDLE;
            S_IDLE: begin
                if (r_cfg_pend)        w_next = S_INIT_COL;
                else if (r_timer == '0) w_next = S_RD_STAT;
            end
            S_RD_STAT:    w_next = S_CAP_STAT;
            S_CAP_STAT:   w_next = (w_words >= 8'd3) ? S_RD_ID : S_IDLE;
            S_RD_ID:      w_next = S_CAP_ID;
            S_CAP_ID:     w_next = w_id_ok ? S_RD_TL : S_INIT_FLUSH;
            S_RD_TL:      w_next = S_CAP_TL;
            S_CAP_TL:     w_next = S_RD_BR;
            S_RD_BR:      w_next = S_CAP_BR;
            S_CAP_BR:     w_next = S_OUT;
            S_OUT: begin
                if (bus.bb_ready) w_next = (r_words >= 8'd6) ? S_RD_STAT : S_IDLE;
            end
            default:      w_next = S_INIT_FLUSH;
        endcase
    end

    // Bus strobes decoded from the current state; chipselect mirrors read|write.
    always_comb begin
        bus.m_read      = 1'b0;
        bus.m_write     = 1'b0;
        bus.m_address   = ADDR_STATUS;
        bus.m_writedata = 32'h0;
        case (r_state)
            S_INIT_FLUSH: begin
                bus.m_write     = r_armed;
                bus.m_writedata = r_armed ? 32'h10 : 32'h0;
            end
            S_INIT_COL: begin
                bus.m_write     = 1'b1;
                bus.m_address   = ADDR_BBCOL;
                bus.m_writedata = {8'h0, r_col};
            end
            S_RD_STAT: bus.m_read = 1'b1;
            S_RD_ID, S_RD_TL, S_RD_BR: begin
                bus.m_read    = 1'b1;
                bus.m_address = ADDR_MSG;
            end
            default: ;
        endcase
        bus.m_chipselect = bus.m_read | bus.m_write;
    end

    // Sequencer state, poll timer, message capture and record/config registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_INIT_FLUSH;
            r_armed    <= 1'b0;
            r_timer    <= TIMER_LOAD;
            r_words    <= 8'h0;
            r_err      <= 8'h0;
            r_cfg_pend <= 1'b0;
            r_col      <= BB_COL_INIT;
            r_tl_x     <= 11'h0;
            r_tl_y     <= 11'h0;
            r_x_min    <= 11'h0;
            r_y_min    <= 11'h0;
            r_x_max    <= 11'h0;
            r_y_max    <= 11'h0;
            r_none     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of order.
            r_state <= w_next;
            r_armed <= 1'b1;

            // Timer reloads whenever we are outside IDLE, so each IDLE visit waits a full interval.
            if (r_state != S_IDLE)   r_timer <= TIMER_LOAD;
            else if (r_timer != '0)  r_timer <= r_timer - 1'b1;

            if (r_state == S_CAP_STAT) r_words <= w_words;

            if (r_state == S_CAP_ID && !w_id_ok && r_err != 8'hff) r_err <= r_err + 8'd1;

            if (r_state == S_CAP_TL) begin
                r_tl_x <= w_rd_x;
                r_tl_y <= w_rd_y;
            end

            // Record fields change only on entry to OUT; valid drops after the handshake.
            if (r_state == S_CAP_BR) begin
                r_x_min <= r_tl_x;
                r_y_min <= r_tl_y;
                r_x_max <= w_rd_x;
                r_y_max <= w_rd_y;
                r_none  <= (r_tl_x > w_rd_x) | (r_tl_y > w_rd_y);
                r_valid <= 1'b1;
            end else if (r_state == S_OUT && bus.bb_ready) begin
                r_valid <= 1'b0;
            end

            // A colour update is sticky until the next BBCOL write; a fresh pulse wins over the clear.
            if (cfg_update) begin
                r_cfg_pend <= 1'b1;
                r_col      <= bb_col_cfg;
            end else if (r_state == S_INIT_COL) begin
                r_cfg_pend <= 1'b0;
            end
        end
    end

    assign bus.bb_valid = r_valid;
    assign bus.bb_x_min = r_x_min;
    assign bus.bb_y_min = r_y_min;
    assign bus.bb_x_max = r_x_max;
    assign bus.bb_y_max = r_y_max;
    assign bus.bb_none  = r_none;
    assign err_count    = r_err;

endmodule
